// File: rtl/instr_prog_mem.sv
// Instruction program memory: a streamed loader writes words into an inferred block RAM,
// and a pipelined fetch port reads from it while no load is in progress.
module instr_prog_mem #(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [$clog2(DEPTH)-1:0]   load_base,
    input  logic [$clog2(DEPTH):0]     load_len,
    input  logic                       ld_valid,
    input  logic [INSTR_WIDTH-1:0]     ld_data,
    output logic                       ld_ready,
    output logic                       load_busy,
    output logic                       load_done,
    output logic                       load_err,
    input  logic                       fetch_en,
    input  logic [$clog2(DEPTH)-1:0]   fetch_addr,
    output logic [INSTR_WIDTH-1:0]     fetch_data,
    output logic                       fetch_valid
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      ptr_q;
    logic [AW:0]        cnt_q;
    logic               ld_ready_q;
    logic               load_busy_q;
    logic               load_done_q;
    logic               load_err_q;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic wr_en;
    logic rd_en;

    assign wr_en = (state_q == LOAD) && ld_valid && !rst;
    assign rd_en = (state_q == IDLE) && fetch_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            ld_ready_q  <= 1'b0;
            load_busy_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        if (load_len == '0) begin
                            load_done_q <= 1'b1;
                        end else if (load_len > (AW+1)'(DEPTH)) begin
                            load_err_q <= 1'b1;
                        end else begin
                            ptr_q       <= load_base;
                            cnt_q       <= load_len;
                            state_q     <= LOAD;
                            ld_ready_q  <= 1'b1;
                            load_busy_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        // Pointer wraps naturally at DEPTH since it is exactly AW bits wide.
                        ptr_q <= ptr_q + AW'(1);
                        cnt_q <= cnt_q - (AW+1)'(1);
                        if (cnt_q == (AW+1)'(1)) begin
                            state_q     <= DONE;
                            ld_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    load_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    ld_ready_q  <= 1'b0;
                    load_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= ld_data;
        end
    end

    // Stage 0 is the RAM read register; further stages are plain output registers.
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
        logic [INSTR_WIDTH-1:0] data_q;
        logic                   valid_q;
        if (gi == 0) begin : g_ram_rd
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    data_q <= mem[fetch_addr];
                end
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en;
                end
            end
        end else begin : g_out_reg
            always_ff @(posedge clk) begin
                data_q <= g_stage[gi-1].data_q;
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= g_stage[gi-1].valid_q;
                end
            end
        end
    end

    assign fetch_data  = g_stage[RD_LATENCY-1].data_q;
    assign fetch_valid = g_stage[RD_LATENCY-1].valid_q;
    assign ld_ready    = ld_ready_q;
    assign load_busy   = load_busy_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_instr_prog_mem.sv
// Directed bench for instr_prog_mem with a cycle-level reference model and literal spot checks.
module tb_instr_prog_mem;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int RDL   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [W-1:0]  fetch_data;
    logic          fetch_valid;

    always #5 clk = ~clk;

    instr_prog_mem #(
        .INSTR_WIDTH(W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reference model: memory image, load progress and fetch returns due at a given cycle.
    typedef struct {
        int           due;
        logic [W-1:0] d;
    } fexp_t;

    logic [W-1:0] m_mem [DEPTH];
    bit           m_loading = 0;
    bit           m_in_done = 0;
    int           m_left = 0;
    int           m_ptr = 0;
    int           cyc = 0;
    bit           exp_ready = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
    fexp_t        fq[$];
    bit           cmp_on = 0;

    always @(posedge clk) begin
        bit busy_now, nd, ne;
        cyc = cyc + 1;
        if (rst) begin
            m_loading = 0;
            m_in_done = 0;
            exp_ready = 0;
            exp_busy  = 0;
            exp_done  = 0;
            exp_err   = 0;
            fq.delete();
        end else begin
            busy_now = m_loading || m_in_done;
            if (fetch_en && !busy_now) begin
                fq.push_back('{due: cyc + RDL - 1, d: m_mem[int'(fetch_addr)]});
            end
            nd = 0;
            ne = 0;
            if (m_in_done) begin
                m_in_done = 0;
            end else if (m_loading) begin
                if (ld_valid) begin
                    m_mem[m_ptr] = ld_data;
                    m_ptr  = (m_ptr + 1) % DEPTH;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_loading = 0;
                        m_in_done = 1;
                    end
                end
            end else if (load_start) begin
                if (int'(load_len) == 0) nd = 1;
                else if (int'(load_len) > DEPTH) ne = 1;
                else begin
                    m_loading = 1;
                    m_ptr     = int'(load_base);
                    m_left    = int'(load_len);
                end
            end
            exp_done  = nd || m_in_done;
            exp_err   = ne;
            exp_ready = m_loading;
            exp_busy  = m_loading || m_in_done;
        end
    end

    always @(negedge clk) begin
        bit exp_fv;
        if (cmp_on) begin
            chk("ld_ready", 32'(ld_ready), 32'(exp_ready));
            chk("load_busy", 32'(load_busy), 32'(exp_busy));
            chk("load_done", 32'(load_done), 32'(exp_done));
            chk("load_err", 32'(load_err), 32'(exp_err));
            exp_fv = (fq.size() > 0) && (fq[0].due == cyc);
            chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
            if (exp_fv) begin
                chk("fetch_data", fetch_data, fq[0].d);
                void'(fq.pop_front());
            end
        end
    end

    logic [W-1:0] got[$];
    int           done_pulses = 0;

    always @(negedge clk) begin
        if (fetch_valid === 1'b1) got.push_back(fetch_data);
        if (load_done === 1'b1) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(int base, int len);
        load_start = 1'b1;
        load_base  = AW'(base);
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic read_word(int addr, logic [W-1:0] exp, string name);
        int waited;
        got.delete();
        fetch_en   = 1'b1;
        fetch_addr = AW'(addr);
        tick();
        fetch_en = 1'b0;
        waited = 0;
        while (got.size() == 0 && waited < 8) begin
            tick();
            waited++;
        end
        if (got.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s no fetch_valid within 8 cycles, required data=%h", name, exp);
        end else begin
            chk(name, got[0], exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_ld_ready", 32'(ld_ready), 0);
        chk("rst_load_busy", 32'(load_busy), 0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        rst = 1'b0;
        cmp_on = 1;

        // Fill the whole RAM (len == DEPTH) so every address has a known value.
        start_load(0, DEPTH);
        ld_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_data = 32'h0000_1000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        repeat (2) tick();
        chk("init_m_mem15", m_mem[15], 32'h0000_100F);

        // Load A0..A3 at base 0, then fetch back-to-back right after load_done.
        start_load(0, 4);
        chk("s1_ld_ready", 32'(ld_ready), 1);
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'h0000_00A0 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        chk("s1_done_pulse", 32'(load_done), 1);
        chk("s1_busy_in_done", 32'(load_busy), 1);
        tick();
        chk("s1_done_low", 32'(load_done), 0);
        got.delete();
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = AW'(i);
            tick();
        end
        fetch_en = 1'b0;
        repeat (4) tick();
        chk("s1_fetch_count", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("s1_word0", got[0], 32'h0000_00A0);
            chk("s1_word1", got[1], 32'h0000_00A1);
            chk("s1_word2", got[2], 32'h0000_00A2);
            chk("s1_word3", got[3], 32'h0000_00A3);
        end

        // Wrap-around load from DEPTH-2.
        start_load(DEPTH - 2, 4);
        ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_data = 32'h0000_00B0 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        repeat (2) tick();
        read_word(14, 32'h0000_00B0, "s2_addr14");
        read_word(15, 32'h0000_00B1, "s2_addr15");
        read_word(0, 32'h0000_00B2, "s2_addr0");
        read_word(1, 32'h0000_00B3, "s2_addr1");
        read_word(2, 32'h0000_00A2, "s2_addr2_kept");

        // Zero-length load completes immediately; oversize load is rejected.
        start_load(3, 0);
        chk("s3_zero_done", 32'(load_done), 1);
        chk("s3_zero_busy", 32'(load_busy), 0);
        tick();
        chk("s3_zero_done_low", 32'(load_done), 0);
        start_load(3, DEPTH + 1);
        chk("s3_err", 32'(load_err), 1);
        chk("s3_err_busy", 32'(load_busy), 0);
        tick();
        chk("s3_err_low", 32'(load_err), 0);
        read_word(3, 32'h0000_00A3, "s3_addr3");
        read_word(4, 32'h0000_1004, "s3_addr4");

        // Stalled load with a fetch attempted mid-load.
        done_pulses = 0;
        start_load(4, 3);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = (i % 2 == 0) ? 32'h0000_00C0 + 32'(i / 2) : 32'hDEAD_BEEF;
            fetch_en   = (i == 1);
            fetch_addr = AW'(5);
            tick();
        end
        ld_valid = 1'b0;
        fetch_en = 1'b0;
        repeat (4) tick();
        chk("s4_no_fetch", 32'(got.size()), 0);
        chk("s4_done_pulses", 32'(done_pulses), 1);
        read_word(4, 32'h0000_00C0, "s4_addr4");
        read_word(5, 32'h0000_00C1, "s4_addr5");
        read_word(6, 32'h0000_00C2, "s4_addr6");
        read_word(7, 32'h0000_1007, "s4_addr7");

        // Reset after two of five words.
        start_load(8, 5);
        ld_valid = 1'b1;
        ld_data = 32'h0000_00D0;
        tick();
        ld_data = 32'h0000_00D1;
        tick();
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_ld_ready", 32'(ld_ready), 0);
        chk("s5_load_busy", 32'(load_busy), 0);
        read_word(8, 32'h0000_00D0, "s5_addr8");
        read_word(9, 32'h0000_00D1, "s5_addr9");
        read_word(10, 32'h0000_100A, "s5_addr10");
        read_word(11, 32'h0000_100B, "s5_addr11");
        read_word(12, 32'h0000_100C, "s5_addr12");

        // load_start during LOAD is ignored.
        start_load(12, 2);
        ld_valid   = 1'b1;
        ld_data    = 32'h0000_00E0;
        load_start = 1'b1;
        load_base  = AW'(0);
        load_len   = (AW+1)'(3);
        tick();
        load_start = 1'b0;
        ld_data = 32'h0000_00E1;
        tick();
        ld_valid = 1'b0;
        chk("s6_done", 32'(load_done), 1);
        repeat (2) tick();
        read_word(12, 32'h0000_00E0, "s6_addr12");
        read_word(13, 32'h0000_00E1, "s6_addr13");
        read_word(0, 32'h0000_00B2, "s6_addr0_kept");
        read_word(14, 32'h0000_00B0, "s6_addr14_kept");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prog_mem.md
INSTR_PROG_MEM -- requirements
Module: instr_prog_mem

Interface
REQ-001 The block SHALL have parameter INSTR_WIDTH, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, number of words; power of two, minimum 4.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, fetch read latency in cycles; legal values 1 or 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port load_start, input, 1 bit: one-cycle request to begin a program load.
REQ-007 The block SHALL have port load_base, input, $clog2(DEPTH) bits: first write address of the load.
REQ-008 The block SHALL have port load_len, input, $clog2(DEPTH)+1 bits: number of words to load.
REQ-009 The block SHALL have port ld_valid, input, 1 bit: ld_data holds a valid word.
REQ-010 The block SHALL have port ld_data, input, INSTR_WIDTH bits: load word.
REQ-011 The block SHALL have port ld_ready, output, 1 bit: block accepts a load word this cycle.
REQ-012 The block SHALL have port load_busy, output, 1 bit: a load is in progress.
REQ-013 The block SHALL have port load_done, output, 1 bit: one-cycle pulse at load completion.
REQ-014 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load request is rejected.
REQ-015 The block SHALL have port fetch_en, input, 1 bit: fetch request.
REQ-016 The block SHALL have port fetch_addr, input, $clog2(DEPTH) bits: fetch address.
REQ-017 The block SHALL have port fetch_data, output, INSTR_WIDTH bits: fetched instruction.
REQ-018 The block SHALL have port fetch_valid, output, 1 bit: fetch_data is valid this cycle.

Function
REQ-019 The block SHALL implement FSM states IDLE, LOAD and DONE, and SHALL use an inferred block RAM of DEPTH x INSTR_WIDTH.
REQ-020 In IDLE, when load_start=1 and 1<=load_len<=DEPTH, the block SHALL capture load_base into a pointer and load_len into a counter, then enter LOAD.
REQ-021 In IDLE, when load_start=1 and load_len=0, the block SHALL perform no write, pulse load_done on the next cycle and remain in IDLE.
REQ-022 In IDLE, when load_start=1 and load_len>DEPTH, the block SHALL perform no write, pulse load_err on the next cycle and remain in IDLE.
REQ-023 In LOAD, ld_ready SHALL be 1, and load_busy SHALL be 1 in LOAD and DONE; both SHALL be 0 otherwise.
REQ-024 Each cycle with ld_valid&&ld_ready, the block SHALL write ld_data to mem[pointer], increment the pointer modulo DEPTH (wrapping DEPTH-1 to 0) and decrement the counter.
REQ-025 When the word that brings the counter to 0 is accepted, the block SHALL enter DONE; DONE SHALL assert load_done for exactly one cycle, then return to IDLE.
REQ-026 ld_valid=0 during LOAD SHALL stall the load with no timeout.
REQ-027 load_start while load_busy=1 SHALL be ignored, with no effect on state, pointer, counter or load_err.
REQ-028 In IDLE, fetch_en=1 SHALL return mem[fetch_addr] on fetch_data with fetch_valid=1 exactly RD_LATENCY cycles later; back-to-back fetches SHALL be fully pipelined at one per cycle.
REQ-029 When RD_LATENCY=2, the block SHALL add an output register after the RAM read register.
REQ-030 Any fetch_en asserted while load_busy=1 SHALL be dropped, producing no fetch_valid; fetches already in flight SHALL complete normally.
REQ-031 A fetch issued in the cycle after load_done SHALL return the newly loaded data.
REQ-032 fetch_data SHALL be don't-care whenever fetch_valid=0.

Reset
REQ-033 While rst=1 at a clock edge, the FSM SHALL return to IDLE, and ld_ready, load_busy, load_done, load_err and fetch_valid SHALL all be 0, with in-flight fetches discarded.
REQ-034 RAM contents SHALL NOT be cleared by reset; a reset during LOAD SHALL abort the load and keep any words already written.

Verification
REQ-035 The bench SHALL cover this case: load base=0, len=4, data A0..A3 with continuous ld_valid; then fetch addresses 0..3 back-to-back -> load_done one cycle after the 4th accept, then fetch_valid on 4 consecutive cycles returning A0..A3 with RD_LATENCY latency.
REQ-036 The bench SHALL cover this case: load base=DEPTH-2, len=4 -> words written to addresses DEPTH-2, DEPTH-1, 0 and 1.
REQ-037 The bench SHALL cover this case: load_len=0, then load_len=DEPTH+1 -> load_done pulse with RAM unchanged, then load_err pulse with RAM unchanged.
REQ-038 The bench SHALL cover this case: load len=3 with ld_valid toggled 1,0,1,0,1 and fetch_en asserted mid-load -> exactly 3 writes, no fetch_valid for the mid-load fetch, one load_done pulse.
REQ-039 The bench SHALL cover this case: rst pulsed after 2 of 5 words -> IDLE with ld_ready=0 and load_busy=0; the 2 words are readable and addresses base+2..base+4 are unchanged.
REQ-040 The bench SHALL cover this case: load_start during LOAD with different base and len -> ignored, and the original load completes.
